// File: rtl/trng_harvester_pkg.sv
// Shared definitions for the TRNG harvester: FSM encoding, word width,
// default cycle counts and the cell drive decode.
package trng_harvester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CRST   = 3'd1,
      ST_ARM    = 3'd2,
      ST_RUN    = 3'd3,
      ST_SAMPLE = 3'd4
   } state_e;

   localparam int WORD_W         = 32;
   localparam int DEF_NUM_CELLS  = 4;
   localparam int DEF_RST_CYCLES = 4;
   localparam int DEF_ARM_CYCLES = 2;
   localparam int DEF_RUN_CYCLES = 16;

   // Returns {T, I1, I2}; the arm pair alternates with round parity.
   function automatic logic [2:0] cell_drive(input state_e s, input logic par);
      case (s)
         ST_IDLE, ST_CRST:  return 3'b000;
         ST_ARM:            return {1'b0, ~par, par};
         ST_RUN, ST_SAMPLE: return {1'b1, ~par, par};
         default:           return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/trng_harvester_osc_sync.sv
// Two-flop synchronizer for one asynchronous oscillator output.
module osc_sync (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next-state for the synchronizer chain.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer flops.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/trng_harvester.sv
// Sequences the oscillator cells through reset/arm/run/sample rounds,
// von Neumann debiases the sampled bits and assembles 32-bit words.
module trng_harvester
   import trng_harvester_pkg::*;
#(
   parameter int NUM_CELLS  = DEF_NUM_CELLS,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   parameter int ARM_CYCLES = DEF_ARM_CYCLES,
   parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 en,
   input  logic [NUM_CELLS-1:0] osc_in,
   output logic                 cell_t,
   output logic                 cell_i1,
   output logic                 cell_i2,
   output logic [WORD_W-1:0]    rnd_data,
   output logic                 rnd_valid,
   input  logic                 rnd_ready
);
   logic [NUM_CELLS-1:0] osc_s;

   for (genvar g = 0; g < NUM_CELLS; g++) begin : g_sync
      osc_sync u_sync (.clk(clk), .resetn(resetn), .d(osc_in[g]), .q(osc_s[g]));
   end

   state_e            state_q, state_d;
   logic [15:0]       cyc_q, cyc_d;
   logic              parity_q, parity_d;
   logic              pend_q, pend_d;
   logic              first_q, first_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic [2:0]        cell_q, cell_d;
   logic              raw_s;
   logic              word_done_s;

   // Round sequencing, debiasing and word assembly.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      pend_d      = pend_q;
      first_d     = first_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      raw_s       = ^osc_s;
      word_done_s = 1'b0;

      if (valid_q && rnd_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (state_q == ST_SAMPLE) begin
         parity_d = ~parity_q;
      end else begin
         parity_d = parity_q;
      end

      if (!en) begin
         state_d = ST_IDLE;
         cyc_d   = 16'd0;
         pend_d  = 1'b0;
         cnt_d   = 6'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cyc_d = 16'd0;
               if (!valid_q) begin
                  state_d = ST_CRST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CRST: begin
               if (cyc_q == 16'(RST_CYCLES - 1)) begin
                  state_d = ST_ARM;
                  cyc_d   = 16'd0;
               end else begin
                  cyc_d = cyc_q + 16'd1;
               end
            end
            ST_ARM: begin
               if (cyc_q == 16'(ARM_CYCLES - 1)) begin
                  state_d = ST_RUN;
                  cyc_d   = 16'd0;
               end else begin
                  cyc_d = cyc_q + 16'd1;
               end
            end
            ST_RUN: begin
               if (cyc_q == 16'(RUN_CYCLES - 1)) begin
                  state_d = ST_SAMPLE;
                  cyc_d   = 16'd0;
               end else begin
                  cyc_d = cyc_q + 16'd1;
               end
            end
            ST_SAMPLE: begin
               cyc_d = 16'd0;
               if (!pend_q) begin
                  pend_d  = 1'b1;
                  first_d = raw_s;
               end else begin
                  pend_d = 1'b0;
                  // 10 emits 1 and 01 emits 0: the emitted bit is the first of the pair.
                  if (first_q != raw_s) begin
                     data_d[cnt_q[4:0]] = first_q;
                     if (cnt_q == 6'd31) begin
                        cnt_d       = 6'd0;
                        valid_d     = 1'b1;
                        word_done_s = 1'b1;
                     end else begin
                        cnt_d = cnt_q + 6'd1;
                     end
                  end else begin
                     cnt_d = cnt_q;
                  end
               end
               if (word_done_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_CRST;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cyc_d   = 16'd0;
            end
         endcase
      end

      cell_d = cell_drive(state_d, parity_d);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         cyc_q    <= 16'd0;
         parity_q <= 1'b0;
         pend_q   <= 1'b0;
         first_q  <= 1'b0;
         cnt_q    <= 6'd0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         cell_q   <= 3'b000;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         parity_q <= parity_d;
         pend_q   <= pend_d;
         first_q  <= first_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         cell_q   <= cell_d;
      end
   end

   assign cell_t    = cell_q[2];
   assign cell_i1   = cell_q[1];
   assign cell_i2   = cell_q[0];
   assign rnd_data  = data_q;
   assign rnd_valid = valid_q;
endmodule

// File: tb/tb_trng_harvester.sv
// Directed-sequence bench with random oscillator patterns, checked against a
// queue-based model of rounds, pair debiasing and word assembly.
module tb_trng_harvester;
   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          en;
   logic [NC-1:0] osc_in;
   logic          cell_t, cell_i1, cell_i2;
   logic [31:0]   rnd_data;
   logic          rnd_valid;
   logic          rnd_ready;

   int errors = 0;
   int checks = 0;

   bit          par_m = 1'b0;
   bit          raw_q[$];
   bit          pending_m = 1'b0;
   logic [31:0] word_m = 32'd0;

   trng_harvester #(
      .NUM_CELLS(NC), .RST_CYCLES(4), .ARM_CYCLES(2), .RUN_CYCLES(16)
   ) dut (
      .clk(clk), .resetn(resetn), .en(en), .osc_in(osc_in),
      .cell_t(cell_t), .cell_i1(cell_i1), .cell_i2(cell_i2),
      .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pairs up the raw bits seen since the last clear; unequal pairs yield their first bit.
   function automatic void debias(output int n, output logic [31:0] w);
      n = 0;
      w = 32'd0;
      for (int i = 0; i + 1 < raw_q.size(); i += 2) begin
         if (raw_q[i] != raw_q[i+1]) begin
            if (n < 32) w[n] = raw_q[i];
            n++;
         end
      end
   endfunction

   // One full round: 4 reset, 2 arm, 17 triggered clocks, then the sample is absorbed.
   task automatic do_round(input bit rawbit);
      logic [NC-1:0] o;
      logic [2:0]    exp_c;
      logic [31:0]   w, mask;
      int            n;
      o = NC'($urandom);
      if ((^o) != rawbit) o[0] = ~o[0];
      osc_in = o;
      for (int k = 0; k < 23; k++) begin
         @(negedge clk);
         if (k < 4)      exp_c = 3'b000;
         else if (k < 6) exp_c = {1'b0, ~par_m, par_m};
         else            exp_c = {1'b1, ~par_m, par_m};
         chk($sformatf("cells_k%0d", k), 64'({cell_t, cell_i1, cell_i2}), 64'(exp_c));
      end
      raw_q.push_back(rawbit);
      par_m = ~par_m;
      debias(n, w);
      @(posedge clk);
      #1;
      if (n >= 32) begin
         chk("valid_set", 64'(rnd_valid), 64'(1));
         chk("word", 64'(rnd_data), 64'(w));
         chk("idle_cells", 64'({cell_t, cell_i1, cell_i2}), 64'(0));
         raw_q.delete();
         pending_m = 1'b1;
         word_m    = w;
      end else begin
         mask = (n == 0) ? 32'd0 : ((32'd1 << n) - 32'd1);
         chk("valid_low", 64'(rnd_valid), 64'(0));
         chk("partial", 64'(rnd_data & mask), 64'(w & mask));
      end
   endtask

   task automatic handshake();
      rnd_ready = 1'b1;
      @(posedge clk);
      #1;
      rnd_ready = 1'b0;
      chk("valid_clear", 64'(rnd_valid), 64'(0));
      pending_m = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bit seq[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int rounds;

      resetn    = 1'b0;
      en        = 1'b1;
      rnd_ready = 1'b0;
      osc_in    = NC'($urandom);
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'({cell_t, cell_i1, cell_i2, rnd_valid, rnd_data}), 64'(0));
      resetn = 1'b1;

      // Debias sequence 0,1,1,0,1,1,0,0 -> bits 0 then 1.
      for (int i = 0; i < 8; i++) do_round(seq[i]);
      chk("debias_cnt", 64'(dut.cnt_q), 64'(2));
      chk("debias_bits", 64'(rnd_data[1:0]), 64'(2'b10));

      // Random raw bits until a word completes.
      rounds = 0;
      while (!pending_m && rounds < 300) begin
         do_round(1'($urandom_range(0, 1)));
         rounds++;
      end
      chk("word1_done", 64'(pending_m), 64'(1));

      // Backpressure: parked in IDLE with the word held.
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("hold", 64'({rnd_valid, cell_t, cell_i1, cell_i2, rnd_data}),
             64'({1'b1, 3'b000, word_m}));
      end
      @(negedge clk);
      handshake();

      // Alternating pairs 10,01 build 0x55555555.
      for (int i = 0; i < 64; i++) do_round((i % 4 == 0) || (i % 4 == 3));
      chk("word_55", 64'(rnd_data), 64'(32'h55555555));
      chk("word2_valid", 64'(rnd_valid), 64'(1));

      // Dropping enable while a word is pending keeps it.
      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      chk("en_off_keep", 64'({rnd_valid, rnd_data}), 64'({1'b1, 32'h55555555}));
      en = 1'b1;
      repeat (3) @(negedge clk);
      chk("en_on_keep", 64'({rnd_valid, cell_t, rnd_data}), 64'({1'b1, 1'b0, 32'h55555555}));
      handshake();

      for (int i = 0; i < 3; i++) do_round(1'($urandom_range(0, 1)));

      // Disable during RUN.
      osc_in = NC'($urandom);
      for (int k = 0; k < 10; k++) @(negedge clk);
      chk("in_run", 64'(cell_t), 64'(1));
      en = 1'b0;
      @(negedge clk);
      chk("dis_cells", 64'({cell_t, cell_i1, cell_i2}), 64'(0));
      chk("dis_cnt", 64'(dut.cnt_q), 64'(0));
      chk("dis_pend", 64'(dut.pend_q), 64'(0));
      chk("dis_valid", 64'(rnd_valid), 64'(0));
      raw_q.delete();
      en = 1'b1;
      for (int i = 0; i < 2; i++) do_round(1'($urandom_range(0, 1)));

      // Reset mid-round clears everything asynchronously.
      for (int k = 0; k < 8; k++) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("midrst_outs", 64'({cell_t, cell_i1, cell_i2, rnd_valid, rnd_data}), 64'(0));
      chk("midrst_cnt", 64'(dut.cnt_q), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/trng_harvester.md
TRNG_HARVESTER -- requirements
Module: trng_harvester

Interface
REQ-001 Parameter NUM_CELLS, default 4: number of oscillator cells driven and sampled.
REQ-002 Parameter RST_CYCLES, default 4: clocks the cells are held in reset (T=0, I1=0, I2=0).
REQ-003 Parameter ARM_CYCLES, default 2: clocks the cells are held armed before trigger.
REQ-004 Parameter RUN_CYCLES, default 16: clocks of free-running oscillation before sampling, minimum 1.
REQ-005 Port clk, input, 1: single system clock; all state is on its rising edge.
REQ-006 Port resetn, input, 1: asynchronous active-low reset.
REQ-007 Port en, input, 1: harvesting enable.
REQ-008 Port osc_in, input, NUM_CELLS: asynchronous OSC outputs of the cells.
REQ-009 Port cell_t, output, 1: trigger T, shared by all cells.
REQ-010 Port cell_i1, output, 1: arm input I1, shared by all cells.
REQ-011 Port cell_i2, output, 1: arm input I2, shared by all cells.
REQ-012 Port rnd_data, output, 32: assembled random word.
REQ-013 Port rnd_valid, output, 1: rnd_data holds a complete word.
REQ-014 Port rnd_ready, input, 1: consumer accepts the word.

Function
REQ-015 FSM states: IDLE, CRST, ARM, RUN, SAMPLE.
REQ-016 IDLE: cell_t, cell_i1 and cell_i2 are all 0. Go to CRST when en=1 and rnd_valid=0.
REQ-017 CRST: cell outputs are 000 for exactly RST_CYCLES clocks, then go to ARM.
REQ-018 ARM: cell_t=0, and (cell_i1, cell_i2) is (1,0) on even rounds or (0,1) on odd rounds, held for exactly ARM_CYCLES clocks, then go to RUN.
REQ-019 Round parity: 1-bit register, reset 0, toggled on each SAMPLE exit.
REQ-020 RUN: cell_t=1 with arm values held, for exactly RUN_CYCLES clocks, then go to SAMPLE.
REQ-021 SAMPLE: one clock with cell_t=1. The raw bit is the XOR of all synchronized osc_in bits. Next state is CRST, or IDLE if en=0 or a word is pending.
REQ-022 Each osc_in bit passes through a 2-flop synchronizer, reset 0, before any use.
REQ-023 Von Neumann debiasing: raw bits are paired (first, second). 01 outputs bit 0, 10 outputs bit 1, 00 and 11 are discarded. A pair-pending flag holds the first bit.
REQ-024 Debiased bits shift into rnd_data LSB-first at bit index 0..31, tracked by a 6-bit counter.
REQ-025 On the 32nd bit, rnd_valid is set on the next clock and the counter clears.
REQ-026 Handshake: a word transfers on a clock with rnd_valid=1 and rnd_ready=1. rnd_valid then clears.
REQ-027 rnd_data is stable while rnd_valid=1. No new word completes while a word is pending; the FSM parks in IDLE.
REQ-028 If en falls in any state: go to IDLE on the next clock, drive cells 000, clear the pair flag and bit counter, and keep any pending valid word.
REQ-029 A word completing on the same clock as a handshake is impossible by construction, because completion requires rnd_valid=0.

Reset
REQ-030 On resetn low, asynchronously: state=IDLE, cell_t=cell_i1=cell_i2=0, rnd_data=0, rnd_valid=0, counter=0, pair flag=0, parity=0, synchronizers=0.
REQ-031 Reset deassertion mid-operation restarts from IDLE. No partial word survives.

Structure
REQ-032 A shared package holds the FSM state encoding, the word width constant (32) and the default cycle constants.
REQ-033 Sub-module osc_sync is a per-bit 2-flop synchronizer, instantiated NUM_CELLS times.
REQ-034 The cells are not instantiated inside trng_harvester; they connect at the top level.

Verification
REQ-035 Reset check: en=1 with resetn low -> all outputs 0. Release -> CRST starts 1 clock later, cell outputs 000 for 4 clocks.
REQ-036 Round timing: round 0 -> I1=1, I2=0 for 2 clocks, then T=1 for 17 clocks (RUN plus SAMPLE). Round 1 -> I1=0, I2=1.
REQ-037 Debias check: model forces raw sequence 0,1,1,0,1,1,0,0 -> exactly 2 bits emitted, 0 then 1.
REQ-038 Word assembly: raw pairs alternate 10,01 for 64 samples -> rnd_data=32'h55555555 and rnd_valid=1.
REQ-039 Backpressure: rnd_ready=0 for 100 clocks -> rnd_data unchanged and FSM in IDLE. rnd_ready=1 -> valid clears and CRST starts.
REQ-040 Disable mid-run: en=0 during RUN -> cells 000 next clock, bit counter 0, and a pending word is preserved.
